marker_injector: RTL and testbench

MARKER_INJECTOR -- requirements
Module: marker_injector

---
 rtl/marker_injector.sv | 213 +++++++++++++++++++++
 tb/tb_marker_injector.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/marker_injector.sv
// marker_injector
//   Merges phase-marker requests into an ordinary instruction stream. Each
//   accepted marker request is queued in a small FIFO and later emitted as the
//   instruction word "slti x0, x0, imm" with imm = {phase, end}. Markers take
//   strict priority over ordinary instructions at the single registered output
//   stage. The block also tracks which phases are open and flags nesting,
//   orphan-END and illegal-phase errors.
//
// Handshakes: every channel uses valid/ready. A transfer happens in the cycle
//   where valid && ready are both high. Ready never depends on valid on the
//   same channel, and a source holds its payload while valid && !ready.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   req_valid/req_ready marker request channel, payload req_phase, req_end
//   in_valid/in_ready   ordinary instruction channel, payload in_inst
//   out_valid/out_ready output channel, payload out_inst, out_is_marker
//   open_mask           bit p set while phase p is open
//   err_nest            sticky: START emitted for an already-open phase
//   err_orphan          sticky: END emitted for a phase that is not open
//   err_bad_phase       sticky: request with phase 7 accepted (and dropped)
//   err_clear           pulse clearing the sticky error bits (set wins)
//   marker_count        saturating count of markers accepted downstream
module marker_injector #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_phase,
    input  logic             req_end,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_is_marker,
    output logic [6:0]       open_mask,
    output logic             err_nest,
    output logic             err_orphan,
    output logic             err_bad_phase,
    input  logic             err_clear,
    output logic [CNT_W-1:0] marker_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

    // ------------------------------------------------------------------
    // Marker request FIFO. Entries hold the 4-bit immediate {phase, end}.
    // ------------------------------------------------------------------
    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          req_fire;
    logic          push;
    logic          bad_evt;
    logic          pop;
    logic          fifo_empty;
    logic [3:0]    head;

    // Ready only looks at the registered count, so a push can never be
    // popped in the same cycle (no bypass path through the FIFO).
    assign req_ready  = (count < DEPTH_CNT);
    assign req_fire   = req_valid && req_ready;
    assign push       = req_fire && (req_phase != 3'd7);
    assign bad_evt    = req_fire && (req_phase == 3'd7);
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_phase, req_end};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output stage FSM: EMPTY (no word held) / FULL (word held).
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   load_en;
    logic   load_marker;
    logic   load_inst;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if ((state == ST_EMPTY) || out_ready) begin
            if (!fifo_empty || in_valid) begin
                state_next = ST_FULL;
            end else begin
                state_next = ST_EMPTY;
            end
        end
    end

    // Output / control decode
    always_comb begin
        out_valid   = 1'b0;
        load_en     = 1'b0;
        load_marker = 1'b0;
        load_inst   = 1'b0;
        pop         = 1'b0;
        in_ready    = 1'b0;
        out_valid   = (state == ST_FULL);
        load_en     = (state == ST_EMPTY) || out_ready;
        load_marker = load_en && !fifo_empty;
        pop         = load_marker;
        // Ordinary instructions only move when no marker is waiting.
        in_ready    = load_en && fifo_empty;
        load_inst   = in_ready && in_valid;
    end

    // Output payload registers; held whenever no load happens.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_inst      <= '0;
            out_is_marker <= 1'b0;
        end else if (load_marker) begin
            out_inst      <= {8'h00, head, 20'h02013};
            out_is_marker <= 1'b1;
        end else if (load_inst) begin
            out_inst      <= in_inst;
            out_is_marker <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Phase tracking and sticky errors, evaluated when a marker is loaded.
    // ------------------------------------------------------------------
    logic [6:0] head_bit;
    logic       nest_evt;
    logic       orphan_evt;

    // Phase 7 is filtered at push, so the head phase is always 0..6.
    assign head_bit   = 7'b1 << head[3:1];
    assign nest_evt   = load_marker && !head[0] && ((open_mask & head_bit) != '0);
    assign orphan_evt = load_marker &&  head[0] && ((open_mask & head_bit) == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            open_mask <= '0;
        end else if (load_marker) begin
            if (head[0]) begin
                open_mask <= open_mask & ~head_bit;
            end else begin
                open_mask <= open_mask | head_bit;
            end
        end
    end

    // A new error event in the same cycle as err_clear leaves the bit set.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_nest      <= 1'b0;
            err_orphan    <= 1'b0;
            err_bad_phase <= 1'b0;
        end else begin
            err_nest      <= (err_nest      && !err_clear) || nest_evt;
            err_orphan    <= (err_orphan    && !err_clear) || orphan_evt;
            err_bad_phase <= (err_bad_phase && !err_clear) || bad_evt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            marker_count <= '0;
        end else if (out_valid && out_ready && out_is_marker && (marker_count != '1)) begin
            marker_count <= marker_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_marker_injector.sv
// tb_marker_injector
//   Directed bench for marker_injector. Inputs change 1 time unit after the
//   rising edge; outputs are checked in the same window, away from the edge.
//   marker_count is built 4 bits wide so its saturation is reachable.
module tb_marker_injector;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_phase;
    logic        req_end;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_is_marker;
    logic [6:0]  open_mask;
    logic        err_nest;
    logic        err_orphan;
    logic        err_bad_phase;
    logic        err_clear;
    logic [3:0]  marker_count;

    int tests;
    int fails;

    marker_injector #(
        .FIFO_DEPTH (4),
        .CNT_W      (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_phase     (req_phase),
        .req_end       (req_end),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_is_marker (out_is_marker),
        .open_mask     (open_mask),
        .err_nest      (err_nest),
        .err_orphan    (err_orphan),
        .err_bad_phase (err_bad_phase),
        .err_clear     (err_clear),
        .marker_count  (marker_count)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and land 1 unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer_req(input logic [2:0] phase, input logic e);
        req_valid = 1'b1;
        req_phase = phase;
        req_end   = e;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_phase = 3'd0;
        req_end   = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        out_ready = 1'b0;
        err_clear = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_is_marker", 32'(out_is_marker), 32'd0);
        check("rst_open_mask", 32'(open_mask), 32'h0);
        check("rst_errs", {29'd0, err_nest, err_orphan, err_bad_phase}, 32'd0);
        check("rst_count", 32'(marker_count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Phase 0 START: one cycle in the FIFO, then in the output stage
        out_ready = 1'b1;
        offer_req(3'd0, 1'b0);
        step();
        req_valid = 1'b0;
        check("p0s_not_bypassed", 32'(out_valid), 32'd0);
        step();
        check("p0s_valid", 32'(out_valid), 32'd1);
        check("p0s_word", out_inst, 32'h00002013);
        check("p0s_is_marker", 32'(out_is_marker), 32'd1);
        check("p0s_mask", 32'(open_mask), 32'h01);
        step();
        check("p0s_count", 32'(marker_count), 32'd1);
        check("p0s_drained", 32'(out_valid), 32'd0);

        // Phase 6 START then END back to back
        offer_req(3'd6, 1'b0);
        step();
        offer_req(3'd6, 1'b1);
        step();
        req_valid = 1'b0;
        check("p6s_word", out_inst, 32'h00c02013);
        check("p6s_mask", 32'(open_mask), 32'h41);
        step();
        check("p6e_word", out_inst, 32'h00d02013);
        check("p6e_mask", 32'(open_mask), 32'h01);
        step();
        check("p6_count", 32'(marker_count), 32'd3);
        check("p6_drained", 32'(out_valid), 32'd0);

        // Marker priority over an ordinary instruction
        offer_req(3'd1, 1'b0);
        step();
        req_valid = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00000013;
        #1;
        check("prio_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check("prio_marker_first", out_inst, 32'h00202013);
        check("prio_marker_flag", 32'(out_is_marker), 32'd1);
        check("prio_in_ready_high", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("prio_inst_next", out_inst, 32'h00000013);
        check("prio_inst_flag", 32'(out_is_marker), 32'd0);
        check("prio_count", 32'(marker_count), 32'd4);
        step();
        check("prio_drained", 32'(out_valid), 32'd0);
        check("prio_count_hold", 32'(marker_count), 32'd4);

        // Back-pressure: 5 accepted with output stalled, 6th refused
        out_ready = 1'b0;
        offer_req(3'd3, 1'b0);
        step();
        offer_req(3'd3, 1'b1);
        step();
        check("bp_first_loaded", out_inst, 32'h00602013);
        offer_req(3'd4, 1'b0);
        step();
        offer_req(3'd4, 1'b1);
        step();
        offer_req(3'd5, 1'b0);
        step();
        check("bp_full_ready", 32'(req_ready), 32'd0);
        offer_req(3'd0, 1'b1);
        step();
        req_valid = 1'b0;
        check("bp_still_full", 32'(req_ready), 32'd0);
        check("bp_stable_word", out_inst, 32'h00602013);
        check("bp_stable_valid", 32'(out_valid), 32'd1);
        check("bp_mask", 32'(open_mask), 32'h0b);
        out_ready = 1'b1;
        step();
        check("bp_drain1", out_inst, 32'h00702013);
        check("bp_drain1_mask", 32'(open_mask), 32'h03);
        step();
        check("bp_drain2", out_inst, 32'h00802013);
        step();
        check("bp_drain3", out_inst, 32'h00902013);
        step();
        check("bp_drain4", out_inst, 32'h00a02013);
        check("bp_drain4_mask", 32'(open_mask), 32'h23);
        step();
        check("bp_6th_dropped", 32'(out_valid), 32'd0);
        check("bp_count", 32'(marker_count), 32'd9);
        check("bp_ready_again", 32'(req_ready), 32'd1);

        // Orphan END for phase 2
        offer_req(3'd2, 1'b1);
        step();
        req_valid = 1'b0;
        step();
        check("orphan_word", out_inst, 32'h00502013);
        check("orphan_err", 32'(err_orphan), 32'd1);
        check("orphan_no_nest", 32'(err_nest), 32'd0);
        step();
        check("orphan_count", 32'(marker_count), 32'd10);

        // Illegal phase 7: flagged, never emitted
        offer_req(3'd7, 1'b0);
        step();
        req_valid = 1'b0;
        check("bad_err", 32'(err_bad_phase), 32'd1);
        step();
        check("bad_no_output", 32'(out_valid), 32'd0);
        check("bad_count", 32'(marker_count), 32'd10);

        // Nested START for already-open phase 0
        offer_req(3'd0, 1'b0);
        step();
        req_valid = 1'b0;
        step();
        check("nest_word", out_inst, 32'h00002013);
        check("nest_err", 32'(err_nest), 32'd1);
        step();

        // err_clear
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("clear_errs", {29'd0, err_nest, err_orphan, err_bad_phase}, 32'd0);

        // Clear and a new error in the same cycle: error stays set
        offer_req(3'd7, 1'b1);
        err_clear = 1'b1;
        step();
        req_valid = 1'b0;
        check("set_wins", 32'(err_bad_phase), 32'd1);
        step();
        err_clear = 1'b0;
        check("clear_again", 32'(err_bad_phase), 32'd0);

        // Saturation of the 4-bit counter: 11 + 6 markers stays at 15
        check("sat_pre_count", 32'(marker_count), 32'd11);
        offer_req(3'd0, 1'b1);
        step();
        offer_req(3'd1, 1'b1);
        step();
        offer_req(3'd5, 1'b1);
        step();
        offer_req(3'd6, 1'b0);
        step();
        offer_req(3'd6, 1'b1);
        step();
        offer_req(3'd4, 1'b0);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("sat_count", 32'(marker_count), 32'd15);
        check("sat_mask", 32'(open_mask), 32'h10);
        check("sat_no_errs", {30'd0, err_nest, err_orphan}, 32'd0);

        // Reset with a held word and two queued markers
        out_ready = 1'b0;
        offer_req(3'd1, 1'b0);
        step();
        offer_req(3'd2, 1'b0);
        step();
        offer_req(3'd3, 1'b0);
        step();
        check("prerst_valid", 32'(out_valid), 32'd1);
        check("prerst_word", out_inst, 32'h00202013);
        check("prerst_mask", 32'(open_mask), 32'h12);
        reset = 1'b1;
        offer_req(3'd4, 1'b1);
        out_ready = 1'b1;
        step();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_mask", 32'(open_mask), 32'h00);
        check("midrst_count", 32'(marker_count), 32'd0);
        check("midrst_word", out_inst, 32'h0);
        reset     = 1'b0;
        req_valid = 1'b0;
        step();
        step();
        check("postrst_empty", 32'(out_valid), 32'd0);
        check("postrst_count", 32'(marker_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
